gcd_driver: RTL and testbench

Initiator-side sequencer for the subtractive GCD engine (datapath plus controller pair). It accepts an operand pair over a valid/ready handshake and holds the engine in reset between jobs. It drives A and then B onto the engine's shared data bus with start, waits for done, and returns the captured result over a second valid/ready handshake. It lets system logic use the engine without reproducing its load-sequence timing.

---
 rtl/gcd_driver_if.sv | 32 +++
 rtl/gcd_driver.sv | 127 ++++++++++++
 tb/tb_gcd_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gcd_driver_if.sv
// Handshake and engine-bus bundle for gcd_driver: operand/result handshakes plus
// the load/start/done signals shared with the subtractive GCD engine.
interface gcd_driver_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic             eng_rst;
    logic             eng_start;
    logic [WIDTH-1:0] eng_data;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic             busy;

    // Driver side.
    modport master (
        input  in_valid, in_a, in_b, out_ready, eng_done, eng_result,
        output in_ready, out_valid, out_gcd, out_err, eng_rst, eng_start, eng_data, busy
    );

    // System / engine side.
    modport slave (
        output in_valid, in_a, in_b, out_ready, eng_done, eng_result,
        input  in_ready, out_valid, out_gcd, out_err, eng_rst, eng_start, eng_data, busy
    );
endinterface

// File: rtl/gcd_driver.sv
// Sequencer for the subtractive GCD engine: loads A then B, waits for done, returns the result.
// Optional WAIT watchdog enabled with GCD_DRV_TIMEOUT_EN.
module gcd_driver #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 2000
) (
    input  logic         clk,
    input  logic         rst,
    gcd_driver_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic             accept;

`ifdef GCD_DRV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // in_ready is masked by rst so it reads 0 for the whole reset window.
    assign bus.in_ready  = (state_q == S_IDLE) && rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_RESP);
    assign bus.eng_rst   = (state_q == S_IDLE) || (state_q == S_RESP);
    assign bus.eng_start = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_WAIT);
    assign bus.out_gcd   = gcd_q;

    always_comb begin
        bus.eng_data = '0;
        case (state_q)
            S_LOAD_A:        bus.eng_data = a_q;
            S_LOAD_B, S_WAIT: bus.eng_data = b_q;
            default:         bus.eng_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
`ifdef GCD_DRV_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d = bus.in_a;
                    b_d = bus.in_b;
                    // The engine never terminates on a zero operand, so answer directly.
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        gcd_d   = bus.in_a | bus.in_b;
`ifdef GCD_DRV_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                state_d = S_WAIT;
`ifdef GCD_DRV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    gcd_d   = bus.eng_result;
`ifdef GCD_DRV_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef GCD_DRV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
        end
    end

`ifdef GCD_DRV_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver: subtractive engine stub, Euclid reference model, directed and random jobs.
module tb_gcd_driver;
    localparam int W   = 16;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_driver_if #(.WIDTH(W)) bus();
    gcd_driver #(.WIDTH(W), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // Engine stub: samples A then B while start is high, then subtracts until equal.
    logic [W-1:0] ea, eb, la, lb;
    int           phase;
    int           start_cnt;
    logic         hang;

    always @(posedge clk) begin
        if (bus.eng_start) start_cnt <= start_cnt + 1;
        if (bus.eng_rst) begin
            phase        <= 0;
            bus.eng_done <= 1'b0;
        end else if (!hang) begin
            case (phase)
                0: if (bus.eng_start) begin ea <= bus.eng_data; la <= bus.eng_data; phase <= 1; end
                1: begin eb <= bus.eng_data; lb <= bus.eng_data; phase <= 2; end
                default: if (!bus.eng_done) begin
                    if (ea == eb)     bus.eng_done <= 1'b1;
                    else if (ea > eb) ea <= ea - eb;
                    else              eb <= eb - ea;
                end
            endcase
        end
    end
    assign bus.eng_result = ea;

    function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; returns in the cycle after the accept edge.
    task automatic send(logic [W-1:0] a, logic [W-1:0] b);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 3000) begin @(negedge clk); cyc++; end
        if (!bus.out_valid) chk("resp_timeout", 0, 1);
    endtask

    task automatic finish_resp(int hold, logic [W-1:0] eg, logic ee);
        chk("out_gcd", 32'(bus.out_gcd), 32'(eg));
        chk("out_err", 32'(bus.out_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_gcd", 32'(bus.out_gcd), 32'(eg));
            chk("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_eng_rst", 32'(bus.eng_rst), 1);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
    endtask

    task automatic job(logic [W-1:0] a, logic [W-1:0] b, int hold);
        int cyc;
        send(a, b);
        wait_resp(cyc);
        finish_resp(hold, ref_gcd(a, b), 1'b0);
    endtask

    initial begin
        int cyc, s0;
        logic [W-1:0] ra, rb;
        rst = 1'b0; hang = 1'b0; start_cnt = 0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_eng_rst", 32'(bus.eng_rst), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_eng_start", 32'(bus.eng_start), 0);
        chk("rst_eng_data", 32'(bus.eng_data), 0);
        chk("rst_out_gcd", 32'(bus.out_gcd), 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // 81,27 with load-sequence checks
        send(81, 27);
        chk("la_start", 32'(bus.eng_start), 1);
        chk("la_data", 32'(bus.eng_data), 81);
        chk("la_eng_rst", 32'(bus.eng_rst), 0);
        chk("la_in_ready", 32'(bus.in_ready), 0);
        chk("la_busy", 32'(bus.busy), 1);
        @(negedge clk);
        chk("lb_data", 32'(bus.eng_data), 27);
        chk("lb_start", 32'(bus.eng_start), 1);
        @(negedge clk);
        chk("wait_data", 32'(bus.eng_data), 27);
        chk("wait_start", 32'(bus.eng_start), 1);
        wait_resp(cyc);
        chk("eng_saw_a", 32'(la), 81);
        chk("eng_saw_b", 32'(lb), 27);
        finish_resp(0, 27, 1'b0);

        job(48, 18, 0);
        job(17, 17, 0);

        // zero bypass
        s0 = start_cnt;
        send(0, 35);
        chk("zb_valid", 32'(bus.out_valid), 1);
        finish_resp(0, 35, 1'b0);
        send(0, 0);
        chk("zb0_valid", 32'(bus.out_valid), 1);
        finish_resp(0, 0, 1'b0);
        chk("zb_no_start", 32'(start_cnt), 32'(s0));

        job(100, 75, 5);

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom_range(0, 300));
            rb = W'($urandom_range(1, 300));
            if ($urandom_range(0, 7) == 0) rb = '0;
            job(ra, rb, int'($urandom_range(0, 3)));
        end

        // engine that never finishes
        hang = 1'b1;
        send(5, 3);
        @(negedge clk); @(negedge clk);
`ifdef GCD_DRV_TIMEOUT_EN
        cyc = 0;
        while (!bus.out_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("tmo_latency", 32'(cyc), 51);
        finish_resp(0, 0, 1'b1);
`else
        repeat (1000) @(negedge clk);
        chk("hang_no_valid", 32'(bus.out_valid), 0);
        chk("hang_busy", 32'(bus.busy), 1);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
`endif

        // reset mid-WAIT
        send(81, 27);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_eng_rst", 32'(bus.eng_rst), 1);
        chk("mid_eng_start", 32'(bus.eng_start), 0);
        chk("mid_eng_data", 32'(bus.eng_data), 0);
        chk("mid_out_valid", 32'(bus.out_valid), 0);
        chk("mid_in_ready", 32'(bus.in_ready), 0);
        chk("mid_out_err", 32'(bus.out_err), 0);
        @(negedge clk); rst = 1'b1; hang = 1'b0;
        @(negedge clk);
        job(9, 6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
